// File: rtl/mux2_32_arbiter_if.sv
// Bus bundle between the two producers, the shared 2:1 datapath and the consumer.
// The master side drives requests and data words.
// The slave side, the arbiter, returns grants, the mux select and the registered word.
interface mux2_32_arbiter_if;
    logic        reqA;
    logic        reqB;
    logic [31:0] A;
    logic [31:0] B;
    logic        gntA;
    logic        gntB;
    logic        S;
    logic [31:0] Y;
    logic        valid;

    modport master (
        output reqA, reqB, A, B,
        input  gntA, gntB, S, Y, valid
    );

    modport slave (
        input  reqA, reqB, A, B,
        output gntA, gntB, S, Y, valid
    );
endinterface

// File: rtl/mux2_32_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 32-bit 2:1 mux.
// Grants are registered, and so are the select S and the output word Y/valid.
// While the other side is waiting, an owner keeps the datapath for at most
// MAX_BURST transfers.
module mux2_32_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CW        = 2
) (
    input  logic               clk,
    input  logic               reset,
    mux2_32_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic          last_owner, last_nx;  // 0 = A, 1 = B
    logic          s_q, s_nx;
    logic [31:0]   y_q;
    logic          valid_q;
    logic          xfer;

    // A word moves whenever the current owner is still requesting.
    assign xfer = (state == GRANT_A && bus.reqA) || (state == GRANT_B && bus.reqB);

    // Next-state logic: ownership arbitration and the tenure counter.
    always_comb begin
        state_nx = state;
        count_nx = count;
        last_nx  = last_owner;
        s_nx     = s_q;
        unique case (state)
            IDLE: begin
                count_nx = '0;
                // When both request, the side that did not own last wins.
                if (bus.reqA && (!bus.reqB || last_owner))
                    state_nx = GRANT_A;
                else if (bus.reqB)
                    state_nx = GRANT_B;
            end
            GRANT_A: begin
                if (!bus.reqA) begin
                    count_nx = '0;
                    state_nx = bus.reqB ? GRANT_B : IDLE;
                end else if (bus.reqB && count == CNT_MAX) begin
                    count_nx = '0;
                    state_nx = GRANT_B;
                end else if (count != CNT_MAX) begin
                    count_nx = count + 1'b1;
                end
            end
            GRANT_B: begin
                if (!bus.reqB) begin
                    count_nx = '0;
                    state_nx = bus.reqA ? GRANT_A : IDLE;
                end else if (bus.reqA && count == CNT_MAX) begin
                    count_nx = '0;
                    state_nx = GRANT_A;
                end else if (count != CNT_MAX) begin
                    count_nx = count + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // The select and the last owner only move when a new grant begins.
        // In IDLE the select holds, so the mux output does not glitch.
        if (state_nx == GRANT_A && state != GRANT_A) begin
            s_nx    = 1'b0;
            last_nx = 1'b0;
        end else if (state_nx == GRANT_B && state != GRANT_B) begin
            s_nx    = 1'b1;
            last_nx = 1'b1;
        end
    end

    // State and datapath registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            last_owner <= 1'b1;
            s_q        <= 1'b0;
            y_q        <= '0;
            valid_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            last_owner <= last_nx;
            s_q        <= s_nx;
            valid_q    <= xfer;
            if (xfer)
                y_q <= s_q ? bus.B : bus.A;
        end
    end

    assign bus.gntA  = (state == GRANT_A);
    assign bus.gntB  = (state == GRANT_B);
    assign bus.S     = s_q;
    assign bus.Y     = y_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_mux2_32_arbiter.sv
// Testbench for mux2_32_arbiter.
// The stimulus feeds an owner/tenure reference model, which queues the words
// it expects to see.
// A separate monitor compares grants, select and valid every cycle, and pops
// the queue on each valid.
module tb_mux2_32_arbiter;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux2_32_arbiter_if bus();

    mux2_32_arbiter #(.MAX_BURST(MAX_BURST), .CW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit started = 0;

    logic [31:0] exp_q[$];

    // Reference model state, as seen after the most recent edge.
    // Owner encoding: 0 = nobody, 1 = A, 2 = B.
    int          owner = 0;
    int          last  = 2;
    int          tenure = 0;   // transfers so far in the current grant (unsaturated)
    bit          m_s = 0;
    logic [31:0] m_y = '0;
    bit          m_v = 0;
    bit          used_a = 0, used_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, predict what the coming edge does, then commit.
    task automatic step(input bit rst, input bit ra, input bit rb,
                        input logic [31:0] a, input logic [31:0] b);
        int          n_owner, n_last, n_ten;
        bit          n_s, n_v, mine, other;
        logic [31:0] n_y;
        reset = rst; bus.reqA = ra; bus.reqB = rb; bus.A = a; bus.B = b;
        n_owner = owner; n_last = last; n_ten = tenure; n_s = m_s; n_y = m_y; n_v = 0;
        if (rst) begin
            n_owner = 0; n_last = 2; n_ten = 0; n_s = 0; n_y = '0;
        end else begin
            mine  = (owner == 1) ? ra : (owner == 2) ? rb : 1'b0;
            other = (owner == 1) ? rb : ra;
            if (owner != 0 && mine) begin
                n_v = 1;
                n_y = (owner == 1) ? a : b;
                exp_q.push_back(n_y);
            end
            if (owner == 0)
                n_owner = (ra && rb) ? ((last == 1) ? 2 : 1) : ra ? 1 : rb ? 2 : 0;
            else if (!mine)
                n_owner = other ? 3 - owner : 0;
            else if (other && tenure >= MAX_BURST - 1)
                n_owner = 3 - owner;
            if (n_owner != 0 && n_owner != owner) begin
                n_ten = 0; n_last = n_owner; n_s = (n_owner == 2);
            end else if (n_owner != 0) begin
                n_ten = tenure + 1;
            end else begin
                n_ten = 0;
            end
        end
        used_a = n_v && owner == 1;
        used_b = n_v && owner == 2;
        @(posedge clk);
        #1;
        owner = n_owner; last = n_last; tenure = n_ten; m_s = n_s; m_y = n_y; m_v = n_v;
        started = 1;
    endtask

    // Monitor: control outputs every cycle; the word scoreboard on each valid.
    always @(negedge clk) begin
        if (started) begin
            check("gntA", 32'(bus.gntA), 32'(owner == 1));
            check("gntB", 32'(bus.gntB), 32'(owner == 2));
            check("S", 32'(bus.S), 32'(m_s));
            check("valid", 32'(bus.valid), 32'(m_v));
            check("Y_hold", bus.Y, m_y);
            if (bus.valid === 1'b1) begin
                if (exp_q.size() == 0)
                    check("Y_unexpected", bus.Y, 32'hDEAD_BEEF);
                else
                    check("Y_word", bus.Y, exp_q.pop_front());
            end
        end
    end

    localparam logic [31:0] WA = 32'd32767;
    localparam logic [31:0] WB = 32'd16383;

    initial begin
        logic [31:0] cur_a, cur_b;
        bit          ra, rb, rst;
        reset = 1'b1; bus.reqA = 0; bus.reqB = 0; bus.A = '0; bus.B = '0;

        // Reset held with both sides requesting.
        repeat (2) step(1, 1, 1, WA, WB);
        // A alone: grant, then a transfer one edge later.
        repeat (3) step(0, 1, 0, WA, WB);
        step(0, 0, 0, WA, WB);
        // Contention from a fresh reset: A first, bursts of MAX_BURST each.
        step(1, 0, 0, WA, WB);
        repeat (14) step(0, 1, 1, WA, WB);
        // A drops early while B waits: direct handoff.
        step(1, 0, 0, WA, WB);
        repeat (2) step(0, 1, 0, WA, WB);
        step(0, 0, 1, WA, WB);
        repeat (2) step(0, 1, 1, WA, WB);
        // Reset in the middle of a B burst, then A wins again.
        step(1, 1, 1, WA, WB);
        repeat (3) step(0, 1, 1, WA, WB);
        // In GRANT_B, both sides drop: go IDLE, holding Y and S.
        step(1, 0, 0, WA, WB);
        repeat (3) step(0, 0, 1, WA, WB);
        repeat (2) step(0, 0, 0, WA, WB);

        // Random traffic. A waiting requester keeps its word stable.
        cur_a = $urandom; cur_b = $urandom;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            ra  = ($urandom_range(0, 3) != 0);
            rb  = ($urandom_range(0, 3) != 0);
            if (used_a || !bus.reqA) cur_a = $urandom;
            if (used_b || !bus.reqB) cur_b = $urandom;
            step(rst, ra, rb, cur_a, cur_b);
        end
        step(0, 0, 0, cur_a, cur_b);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
